serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised multi-cycle adder/subtractor for the ALU datapath. It processes a WIDTH-bit operand pair DIGIT bits per clock, least-significant digit first, with a carry/borrow chain held in a register between steps. It reports the result with carry/borrow, signed-overflow and zero flags. It sits between the ALU operand registers and the result mux, using valid/ready handshakes on both sides.

## Interface
- WIDTH, 4: operand/result width; must be ≥2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH. Violation is an elaboration error.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  minuend / augend.
- b  in  WIDTH  subtrahend / addend.
- mode  in  1  0 = add, 1 = subtract.
- cin  in  1  carry-in (add) or borrow-in (sub).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  sum or difference, mod 2^WIDTH.
- cout  out  1  carry-out (add) or borrow-out (sub).
- ovf  out  1  two's-complement overflow.
- zero  out  1  result == 0.

## Operation
- STEPS = WIDTH/DIGIT. The FSM has three states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, mode and cin into the shift/chain registers, clear the step counter, and go to BUSY.
- BUSY: each cycle, combine the low DIGIT bits of the a/b shift registers with the chain bit. Shift the result digit into the result register from the MSB side, update the chain bit, and increment the counter. After the STEPS-th step, go to DONE.
- DONE: out_valid=1. All outputs are held stable. On out_ready, go to IDLE.
- Inputs are ignored outside IDLE.
- Add: result = a+b+cin; cout = bit WIDTH of the full sum.
- Sub: result = a−b−cin; cout = 1 iff a < b+cin (unsigned).
- ovf, add: a[MSB]==b[MSB] && result[MSB]!=a[MSB].
- ovf, sub: a[MSB]!=b[MSB] && result[MSB]!=a[MSB].
- ovf uses the latched operand MSBs.
- zero is computed from the final result and registered on entry to DONE.
- Reset at any time forces IDLE and aborts any operation in flight. No out_valid is produced for an aborted operation.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, cout=0, ovf=0, zero=0.
- in_ready is 1 during reset and whenever the state is IDLE.
- Latency: if accept occurs at edge E0, out_valid rises after edge E0+STEPS.
- Out handshake at edge Ex: out_valid falls and in_ready rises after Ex.
- Minimum spacing is STEPS+2 cycles per operation. There is no accept in DONE and no bypass.
- out_ready held low keeps the block in DONE indefinitely with outputs frozen.
- in_valid asserted during BUSY/DONE has no effect. The source must hold its data until in_ready is seen.
- result/flags may change only on the edge entering DONE or during reset.

## Structure
- Shared package alu_pkg holds:
  - MODE_ADD=1'b0 and MODE_SUB=1'b1.
  - The state enum {IDLE, BUSY, DONE}.
- Sub-module addsub_slice: a combinational DIGIT-bit ripple of full add/sub cells.
  - Inputs: a_d, b_d, chain_in, mode.
  - Outputs: d, chain_out.
  - Subtract cell: diff = a^b^c; borrow = (~a&b)|(b&c)|(c&~a).
  - Add cell: standard carry.
- serial_addsub contains the FSM, counter, shift registers, chain register and flag logic.

## Test plan
- WIDTH=4, DIGIT=1, sub, a=3, b=5, cin=0 -> result=4'hE, cout=1, ovf=0, zero=0. out_valid rises exactly 4 cycles after accept.
- Sub, a=9, b=3, cin=0 -> result=6, cout=0, ovf=1.
- Add, a=7, b=1, cin=0 -> result=8, cout=0, ovf=1.
- Add, a=15, b=1 -> result=0, cout=1, zero=1.
- Sub, a=5, b=5, cin=0 -> result=0, zero=1, cout=0.
- Sub, a=0, b=0, cin=1 -> result=15, cout=1, ovf=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs unchanged and in_ready=0 throughout. in_valid pulsed during BUSY is ignored. Release -> in_ready=1 next cycle.
- rst pulsed after 2 BUSY steps -> all outputs at reset values, with no out_valid. A following sub 8−1 -> result=7, cout=0, ovf=1.
- WIDTH=8, DIGIT=2, sub, a=8'h10, b=8'h01 -> result=8'h0F, cout=0, ovf=0. out_valid 4 cycles after accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation mode encodings and the serial adder FSM states.
package alu_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational DIGIT-bit ripple of full adder or full subtractor cells.
module addsub_slice
    import alu_pkg::*;
#(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             chain_in,
    input  logic             mode,
    output logic [DIGIT-1:0] d,
    output logic             chain_out
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        d    = '0;
        c[0] = chain_in;
        for (int i = 0; i < DIGIT; i++) begin
            d[i] = a_d[i] ^ b_d[i] ^ c[i];
            if (mode == MODE_SUB) begin
                c[i+1] = (~a_d[i] & b_d[i]) | (b_d[i] & c[i]) | (c[i] & ~a_d[i]);
            end else begin
                c[i+1] = (a_d[i] & b_d[i]) | (b_d[i] & c[i]) | (c[i] & a_d[i]);
            end
        end
        chain_out = c[DIGIT];
    end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB digit first, with
// carry/borrow, signed-overflow and zero flags; valid/ready on both sides.
module serial_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_next;
    logic             chain, chain_next, op_mode, a_msb, b_msb;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] d;
    logic             res_msb, ovf_next;

    addsub_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a_d      (a_sh[DIGIT-1:0]),
        .b_d      (b_sh[DIGIT-1:0]),
        .chain_in (chain),
        .mode     (op_mode),
        .d        (d),
        .chain_out(chain_next)
    );

    // New digit enters from the MSB side so the full result is aligned after STEPS shifts.
    assign acc_next = (acc >> DIGIT) | (WIDTH'(d) << (WIDTH - DIGIT));
    assign res_msb  = acc_next[WIDTH-1];
    assign ovf_next = (op_mode == MODE_SUB) ? ((a_msb != b_msb) && (res_msb != a_msb))
                                            : ((a_msb == b_msb) && (res_msb != a_msb));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            chain     <= 1'b0;
            op_mode   <= MODE_ADD;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        op_mode  <= mode;
                        chain    <= cin;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    acc   <= acc_next;
                    chain <= chain_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(STEPS - 1)) begin
                        result    <= acc_next;
                        cout      <= chain_next;
                        ovf       <= ovf_next;
                        zero      <= (acc_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: arithmetic reference model with per-cycle compare on a
// 4-bit/1-digit instance, plus directed and random operations on an 8-bit/2-digit one.
module tb_serial_addsub;

    localparam int W = 4;
    localparam int STEPS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, mode, cin, out_valid, out_ready, cout, ovf, zero;
    logic [3:0] a, b, result;

    logic       in_valid8, in_ready8, mode8, cin8, out_valid8, out_ready8, cout8, ovf8, zero8;
    logic [7:0] a8, b8, result8;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    serial_addsub #(.WIDTH(4), .DIGIT(1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .mode(mode), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .mode(mode8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    typedef struct packed {
        logic [7:0] res;
        logic       cout;
        logic       ovf;
        logic       zero;
    } ref_t;

    // Plain integer arithmetic: signed overflow = true result outside the w-bit range.
    function automatic ref_t ref_calc(int w, int unsigned av, int unsigned bv, bit md, bit cn);
        ref_t        r;
        int unsigned m, s;
        int          sa, sb, t;
        m  = 1 << w;
        sa = (av >= m / 2) ? int'(av) - int'(m) : int'(av);
        sb = (bv >= m / 2) ? int'(bv) - int'(m) : int'(bv);
        if (!md) begin
            s      = av + bv + cn;
            r.res  = 8'(s % m);
            r.cout = (s >= m);
            t      = sa + sb + int'(cn);
        end else begin
            s      = (av + 2 * m - bv - cn) % m;
            r.res  = 8'(s);
            r.cout = (av < bv + cn);
            t      = sa - sb - int'(cn);
        end
        r.ovf  = (t < -int'(m / 2)) || (t >= int'(m / 2));
        r.zero = (r.res == 8'd0);
        return r;
    endfunction

    task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model of the 4-bit instance.
    bit         m_pend = 1'b0, m_valid = 1'b0;
    int         m_left = 0;
    ref_t       m_pref;
    logic [3:0] m_res = '0;
    logic       m_cout = 1'b0, m_ovf = 1'b0, m_zero = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend  <= 1'b0;
            m_valid <= 1'b0;
            m_res   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
            m_zero  <= 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_pend) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_pend  <= 1'b0;
                m_valid <= 1'b1;
                m_res   <= m_pref.res[3:0];
                m_cout  <= m_pref.cout;
                m_ovf   <= m_pref.ovf;
                m_zero  <= m_pref.zero;
            end
        end else if (in_valid) begin
            m_pend <= 1'b1;
            m_left <= STEPS;
            m_pref <= ref_calc(W, int'(a), int'(b), mode, cin);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 8'(in_ready), 8'(!m_pend && !m_valid));
            chk("out_valid", 8'(out_valid), 8'(m_valid));
            chk("result", 8'(result), 8'(m_res));
            chk("cout", 8'(cout), 8'(m_cout));
            chk("ovf", 8'(ovf), 8'(m_ovf));
            chk("zero", 8'(zero), 8'(m_zero));
        end
    end

    task automatic op4(string name, logic [3:0] av, logic [3:0] bv, bit md, bit cn,
                       logic [3:0] er, bit ec, bit eo, bit ez);
        int lat;
        @(posedge clk); #1;
        a = av; b = bv; mode = md; cin = cn; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk({name, " latency"}, 8'(lat), 8'(STEPS));
        chk({name, " result"}, 8'(result), 8'(er));
        chk({name, " cout"}, 8'(cout), 8'(ec));
        chk({name, " ovf"}, 8'(ovf), 8'(eo));
        chk({name, " zero"}, 8'(zero), 8'(ez));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " in_ready after take"}, 8'(in_ready), 8'd1);
    endtask

    task automatic op8(string name, logic [7:0] av, logic [7:0] bv, bit md, bit cn, ref_t e);
        int lat;
        @(posedge clk); #1;
        a8 = av; b8 = bv; mode8 = md; cin8 = cn; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid8 && lat < 20);
        chk({name, " latency"}, 8'(lat), 8'd4);
        chk({name, " result"}, result8, e.res);
        chk({name, " cout"}, 8'(cout8), 8'(e.cout));
        chk({name, " ovf"}, 8'(ovf8), 8'(e.ovf));
        chk({name, " zero"}, 8'(zero8), 8'(e.zero));
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    initial begin
        ref_t e;
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; mode = 0; cin = 0; out_ready = 0;
        in_valid8 = 0; a8 = 0; b8 = 0; mode8 = 0; cin8 = 0; out_ready8 = 0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready8", 8'(in_ready8), 8'd1);
        chk("reset result8", result8, 8'd0);
        rst = 1'b0;

        op4("sub 3-5", 4'd3, 4'd5, 1'b1, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0);
        op4("sub 9-3", 4'd9, 4'd3, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
        op4("add 7+1", 4'd7, 4'd1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
        op4("add 15+1", 4'd15, 4'd1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        op4("sub 5-5", 4'd5, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        op4("sub 0-0-1", 4'd0, 4'd0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);

        // Backpressure with an in_valid pulse during BUSY.
        @(posedge clk); #1;
        a = 4'd2; b = 4'd3; mode = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        a = 4'd9; b = 4'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("bp out_valid", 8'(out_valid), 8'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp held result", 8'(result), 8'd5);
            chk("bp held out_valid", 8'(out_valid), 8'd1);
            chk("bp in_ready low", 8'(in_ready), 8'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release in_ready", 8'(in_ready), 8'd1);
        chk("bp release out_valid", 8'(out_valid), 8'd0);

        // Abort after two BUSY steps.
        @(posedge clk); #1;
        a = 4'd6; b = 4'd2; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("abort in_ready", 8'(in_ready), 8'd1);
        chk("abort out_valid", 8'(out_valid), 8'd0);
        chk("abort result", 8'(result), 8'd0);
        chk("abort flags", 8'({cout, ovf, zero}), 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort no out_valid", 8'(out_valid), 8'd0);
        end
        op4("sub 8-1", 4'd8, 4'd1, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);

        // Wide instance: directed then random against the arithmetic model.
        e = '{res: 8'h0F, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        op8("w8 sub 10-01", 8'h10, 8'h01, 1'b1, 1'b0, e);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ra, rb;
            bit         rm, rc;
            ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom); rc = 1'($urandom);
            op8("w8 random", ra, rb, rm, rc, ref_calc(8, int'(ra), int'(rb), rm, rc));
        end

        // Random traffic on the narrow instance; the per-cycle compare does the checking.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom);
            a         = 4'($urandom);
            b         = 4'($urandom);
            mode      = 1'($urandom);
            cin       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
